// File: rtl/drygascon_pkg.sv
// Shared DryGASCON definitions: G-stage FSM states, default state size and the
// 128-bit accumulator fold used after every core round.
package drygascon_pkg;

  localparam int CWORDS64_DEFAULT = 5;

  typedef enum logic [2:0] {IDLE, KICK, WAIT, ACCUM, DONE} g_state_t;

  // Folds the low 256 bits of the state into r: r32[j] ^= c32[j] ^ c32[j+4].
  function automatic logic [127:0] accum128(input logic [127:0] r, input logic [255:0] c);
    logic [127:0] acc;
    acc = r;
    for (int j = 0; j < 4; j++)
      acc[32*j +: 32] = r[32*j +: 32] ^ c[32*j +: 32] ^ c[32*(j+4) +: 32];
    return acc;
  endfunction

endpackage

// File: rtl/drygascon_g_accum_if.sv
// Handshake and data bus between a G-stage requester and drygascon_g_accum.
interface drygascon_g_accum_if #(parameter int CWIDTH = 320);

  logic              start;
  logic [CWIDTH-1:0] c_in;
  logic              busy;
  logic              done;
  logic [CWIDTH-1:0] c_out;
  logic [127:0]      r_out;

  modport master (output start, c_in, input busy, done, c_out, r_out);
  modport slave  (input start, c_in, output busy, done, c_out, r_out);

endinterface

// File: rtl/drygascon_g_accum_core.sv
// Gascon core on a 5x64-bit state, words stored bit-interleaved (even bits low
// half, odd bits high half). Runs ROUND_COUNT rounds after reset release, then holds done.
module Gascon_Core_Round #(
  parameter int ROUND_COUNT = 1,
  parameter int ROUND_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ROUND_W-1:0] round,
  input  logic [319:0]       cin,
  output logic [319:0]       cout,
  output logic               done
);

  logic [319:0]       s;
  logic [ROUND_W-1:0] cnt;

  function automatic logic [31:0] rotr32(input logic [31:0] v, input int k);
    logic [63:0] d;
    d = {v, v} >> k;
    return d[31:0];
  endfunction

  // A 64-bit rotation expressed on the two interleaved 32-bit halves.
  function automatic logic [63:0] rot_il(input logic [63:0] w, input int s_amt);
    if (s_amt % 2 == 0)
      return {rotr32(w[63:32], s_amt/2), rotr32(w[31:0], s_amt/2)};
    return {rotr32(w[31:0], s_amt/2 + 1), rotr32(w[63:32], s_amt/2)};
  endfunction

  function automatic logic [319:0] gascon_round(input logic [319:0] c, input logic [3:0] rc);
    logic [63:0] x [5];
    logic [63:0] t [5];
    for (int i = 0; i < 5; i++) x[i] = c[64*i +: 64];
    x[2] = x[2] ^ {56'd0, 4'hf - rc, rc};
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i+1) % 5];
    for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i+1) % 5];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    x[0] = x[0] ^ rot_il(x[0], 19) ^ rot_il(x[0], 28);
    x[1] = x[1] ^ rot_il(x[1], 61) ^ rot_il(x[1], 38);
    x[2] = x[2] ^ rot_il(x[2], 1)  ^ rot_il(x[2], 6);
    x[3] = x[3] ^ rot_il(x[3], 10) ^ rot_il(x[3], 17);
    x[4] = x[4] ^ rot_il(x[4], 7)  ^ rot_il(x[4], 40);
    return {x[4], x[3], x[2], x[1], x[0]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!done) begin
      s    <= gascon_round((cnt == '0) ? cin : s, 4'(round + cnt));
      cnt  <= cnt + 1'b1;
      done <= (cnt == ROUND_W'(ROUND_COUNT - 1));
    end
  end

  assign cout = s;

endmodule

// File: rtl/drygascon_g_accum.sv
// DryGASCON G stage: ROUNDS Gascon core rounds on the mixed state, folding
// 128 bits of the state into r after every round.
module drygascon_g_accum
  import drygascon_pkg::*;
#(
  parameter int CWORDS64 = CWORDS64_DEFAULT,
  parameter int ROUNDS   = 7,
  parameter int ROUND_W  = 4
) (
  input logic clk,
  input logic reset,
  drygascon_g_accum_if.slave bus
);

  localparam int CWIDTH = 64 * CWORDS64;

  g_state_t           state, next_state;
  logic [ROUND_W-1:0] round;
  logic [CWIDTH-1:0]  c_reg;
  logic [127:0]       r_reg;
  logic               core_rst;
  logic               core_done;
  logic [CWIDTH-1:0]  core_cout;
  logic               busy, done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = KICK;
      KICK:    next_state = WAIT;
      WAIT:    if (core_done) next_state = ACCUM;
      ACCUM:   next_state = (round == ROUND_W'(ROUNDS - 1)) ? DONE : KICK;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // The core reset is registered so it only ever releases during WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round    <= '0;
      c_reg    <= '0;
      r_reg    <= '0;
      core_rst <= 1'b1;
    end else begin
      core_rst <= (next_state != WAIT);
      case (state)
        IDLE:
          if (bus.start) begin
            c_reg <= bus.c_in;
            r_reg <= '0;
            round <= '0;
          end
        WAIT:
          if (core_done) c_reg <= core_cout;
        ACCUM: begin
          r_reg <= accum128(r_reg, c_reg[255:0]);
          if (round != ROUND_W'(ROUNDS - 1)) round <= round + 1'b1;
        end
        default: ;
      endcase
    end
  end

  Gascon_Core_Round #(
    .ROUND_COUNT(1),
    .ROUND_W    (ROUND_W)
  ) u_core (
    .clk  (clk),
    .reset(reset | core_rst),
    .round(round),
    .cin  (c_reg),
    .cout (core_cout),
    .done (core_done)
  );

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.c_out = c_reg;
  assign bus.r_out = r_reg;

endmodule

// File: tb/tb_drygascon_g_accum.sv
// Self-checking bench for drygascon_g_accum against a bit-level reference of the
// Gascon round (S-box table, true 64-bit rotations) and the G accumulation.
module tb_drygascon_g_accum;

  localparam int LC     = 2;
  localparam int R7     = 7;
  localparam int TOTAL7 = R7 * (LC + 2) + 1;
  localparam int TOTAL1 = (LC + 2) + 1;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [319:0] pattern;

  drygascon_g_accum_if #(.CWIDTH(320)) bus7 ();
  drygascon_g_accum_if #(.CWIDTH(320)) bus1 ();

  drygascon_g_accum #(.ROUNDS(7)) dut7 (.clk(clk), .reset(reset), .bus(bus7));
  drygascon_g_accum #(.ROUNDS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] rand_c();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] to_natural(input logic [63:0] w);
    logic [63:0] v;
    for (int i = 0; i < 32; i++) begin
      v[2*i]   = w[i];
      v[2*i+1] = w[32+i];
    end
    return v;
  endfunction

  function automatic logic [63:0] to_stored(input logic [63:0] v);
    logic [63:0] w;
    for (int i = 0; i < 32; i++) begin
      w[i]    = v[2*i];
      w[32+i] = v[2*i+1];
    end
    return w;
  endfunction

  function automatic logic [63:0] rot_model(input logic [63:0] w, input int s);
    logic [63:0] v;
    v = to_natural(w);
    v = (v >> s) | (v << (64 - s));
    return to_stored(v);
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] c, input int rnd);
    logic [63:0] x [5];
    logic [4:0]  col;
    logic [7:0]  k;
    for (int i = 0; i < 5; i++) x[i] = c[64*i +: 64];
    k = 8'((15 - rnd) * 16 + rnd);
    x[2] = x[2] ^ {56'd0, k};
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = SBOX[col];
    end
    x[0] = x[0] ^ rot_model(x[0], 19) ^ rot_model(x[0], 28);
    x[1] = x[1] ^ rot_model(x[1], 61) ^ rot_model(x[1], 38);
    x[2] = x[2] ^ rot_model(x[2], 1)  ^ rot_model(x[2], 6);
    x[3] = x[3] ^ rot_model(x[3], 10) ^ rot_model(x[3], 17);
    x[4] = x[4] ^ rot_model(x[4], 7)  ^ rot_model(x[4], 40);
    return {x[4], x[3], x[2], x[1], x[0]};
  endfunction

  task automatic model_g(input logic [319:0] c_start, input int rounds,
                         output logic [319:0] c_fin, output logic [127:0] r_fin);
    c_fin = c_start;
    r_fin = '0;
    for (int k = 0; k < rounds; k++) begin
      c_fin = model_round(c_fin, k);
      r_fin = r_fin ^ c_fin[127:0] ^ c_fin[255:128];
    end
  endtask

  // One G invocation on the ROUNDS=7 instance; abort_at>0 pulls reset at that cycle.
  task automatic apply_stimulus(input logic [319:0] c, input bit spam, input int abort_at);
    logic [319:0] exp_c;
    logic [127:0] exp_r;
    int done_count;
    int p;
    model_g(c, R7, exp_c, exp_r);
    done_count = 0;
    bus7.start = 1'b1;
    bus7.c_in  = c;
    for (int t = 1; t <= TOTAL7 + 1; t++) begin
      step();
      if (t == abort_at) begin
        reset = 1'b1;
        #1;
        check_output("abort busy", bus7.busy, 0);
        check_output("abort done", bus7.done, 0);
        check_output("abort c_out", bus7.c_out, 0);
        check_output("abort r_out", bus7.r_out, 0);
        bus7.start = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
          step();
          if (bus7.done) done_count++;
        end
        check_output("abort no done", done_count, 0);
        check_output("abort idle", bus7.busy, 0);
        return;
      end
      if (bus7.done) done_count++;
      check_output($sformatf("busy t=%0d", t), bus7.busy, (t <= TOTAL7));
      check_output($sformatf("done t=%0d", t), bus7.done, (t == TOTAL7));
      if (t == 1) begin
        check_output("r restart", bus7.r_out, 0);
        check_output("c load", bus7.c_out, c);
      end
      if (t <= R7 * (LC + 2)) begin
        p = (t - 1) % (LC + 2);
        check_output($sformatf("core rst t=%0d", t), dut7.core_rst, !(p >= 1 && p <= LC));
        if (p >= 1 && p <= LC)
          check_output($sformatf("round idx t=%0d", t), dut7.round, (t - 1) / (LC + 2));
      end
      if (t >= TOTAL7) begin
        check_output($sformatf("c_out t=%0d", t), bus7.c_out, exp_c);
        check_output($sformatf("r_out t=%0d", t), bus7.r_out, exp_r);
      end
      bus7.start = spam && (t <= TOTAL7);
      bus7.c_in  = rand_c();
    end
    check_output("done count", done_count, 1);
  endtask

  initial begin
    logic [319:0] exp_c1;
    logic [127:0] exp_r1;
    reset      = 1'b1;
    bus7.start = 1'b0;
    bus7.c_in  = '0;
    bus1.start = 1'b0;
    bus1.c_in  = '0;
    pattern    = {5{64'h0123456789abcdef}};
    #12;
    check_output("reset busy", bus7.busy, 0);
    check_output("reset done", bus7.done, 0);
    check_output("reset c_out", bus7.c_out, 0);
    check_output("reset r_out", bus7.r_out, 0);
    check_output("reset round", dut7.round, 0);
    check_output("reset busy1", bus1.busy, 0);
    step();
    reset = 1'b0;
    step();

    // Single-round instance on an all-zero state.
    model_g('0, 1, exp_c1, exp_r1);
    bus1.start = 1'b1;
    bus1.c_in  = '0;
    for (int t = 1; t <= TOTAL1 + 1; t++) begin
      step();
      check_output($sformatf("r1 busy t=%0d", t), bus1.busy, (t <= TOTAL1));
      check_output($sformatf("r1 done t=%0d", t), bus1.done, (t == TOTAL1));
      if (t >= TOTAL1) begin
        check_output("r1 c_out", bus1.c_out, exp_c1);
        check_output("r1 r_out", bus1.r_out, exp_r1);
      end
      bus1.start = 1'b0;
      bus1.c_in  = rand_c();
    end

    apply_stimulus(pattern, 1'b0, 0);
    apply_stimulus(pattern, 1'b1, 0);
    apply_stimulus(rand_c(), 1'b0, 0);
    apply_stimulus(rand_c(), 1'b0, 0);
    apply_stimulus(rand_c(), 1'b1, 0);
    apply_stimulus(rand_c(), 1'b0, 3 * (LC + 2) + 2);
    apply_stimulus(pattern, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
